// File: rtl/bali_pkg.sv
// Shared types for the BALI control slice: mover FSM states and LVA index width.
package bali_pkg;

    localparam int unsigned LVA_IDX_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        POP_REQ,
        POP_WAIT,
        WR_REQ,
        WR_WAIT,
        DONE
    } mover_state_t;

endpackage

// File: rtl/move_fifo.sv
// Synchronous FIFO of LVA indices; the caller guarantees no push when full
// (unless popping in the same cycle) and no pop when empty.
module move_fifo
    import bali_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic                 pop,
    input  logic [LVA_IDX_W-1:0] din,
    output logic [LVA_IDX_W-1:0] dout,
    output logic [CNT_W-1:0]     count,
    output logic                 full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [LVA_IDX_W-1:0] mem_q [DEPTH];
    logic [LVA_IDX_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;

    // Pointers are exactly log2(DEPTH) bits wide, so the increment wraps modulo DEPTH.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/lva_mover.sv
// Local-variable mover: queues lvamove requests, pops the eval stack and
// writes each popped word into the LVA at the requested index, in FIFO order.
module lva_mover
    import bali_pkg::*;
#(
    parameter int unsigned LVA_SIZE = 8,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned QDEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 lvamove,
    input  logic [LVA_IDX_W-1:0] lvamoveindex,
    output logic                 lvamovedone,
    output logic                 moveerr,
    output logic                 ovf,
    output logic                 full,
    output logic                 evalpush,
    output logic                 evaltrigger,
    input  logic [DATA_W-1:0]    evalread,
    input  logic                 evaldone,
    output logic                 lvaop,
    output logic                 lvatrigger,
    output logic [LVA_IDX_W-1:0] lvaindex,
    output logic [DATA_W-1:0]    lvawrite,
    input  logic                 lvadone
);

    localparam int unsigned CNT_W = $clog2(QDEPTH) + 1;

    mover_state_t         state_q, state_d;
    logic                 req_vld_q, req_vld_d;
    logic [LVA_IDX_W-1:0] req_idx_q, req_idx_d;
    logic [LVA_IDX_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic                 err_q, err_d;
    logic                 ovf_q, ovf_d;
    logic                 evaltrigger_q, evaltrigger_d;
    logic                 lvatrigger_q, lvatrigger_d;
    logic                 movedone_q, movedone_d;
    logic                 moveerr_q, moveerr_d;

    logic                 fifo_push;
    logic                 fifo_pop;
    logic [LVA_IDX_W-1:0] fifo_dout;
    logic [CNT_W-1:0]     fifo_count;
    logic                 fifo_full;

    move_fifo #(
        .DEPTH (QDEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (req_idx_q),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full)
    );

    // Requests are registered before enqueue; acceptance is judged on that
    // registered copy, so a same-cycle dequeue can make room for it.
    always_comb begin
        req_vld_d = lvamove;
        req_idx_d = lvamoveindex;
        fifo_pop  = (state_q == IDLE) && (fifo_count != '0);
        fifo_push = req_vld_q && (!fifo_full || fifo_pop);
        ovf_d     = ovf_q | (req_vld_q & ~fifo_push);

        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (fifo_pop) begin
                    idx_d = fifo_dout;
                    if (32'(fifo_dout) < LVA_SIZE) begin
                        err_d   = 1'b0;
                        state_d = POP_REQ;
                    end else begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            POP_REQ:  state_d = POP_WAIT;
            POP_WAIT: begin
                if (evaldone) begin
                    data_d  = evalread;
                    state_d = WR_REQ;
                end
            end
            WR_REQ:   state_d = WR_WAIT;
            WR_WAIT:  if (lvadone) state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        evaltrigger_d = (state_d == POP_REQ);
        lvatrigger_d  = (state_d == WR_REQ);
        movedone_d    = (state_d == DONE);
        moveerr_d     = (state_d == DONE) && err_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            req_vld_q     <= 1'b0;
            req_idx_q     <= '0;
            idx_q         <= '0;
            data_q        <= '0;
            err_q         <= 1'b0;
            ovf_q         <= 1'b0;
            evaltrigger_q <= 1'b0;
            lvatrigger_q  <= 1'b0;
            movedone_q    <= 1'b0;
            moveerr_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_vld_q     <= req_vld_d;
            req_idx_q     <= req_idx_d;
            idx_q         <= idx_d;
            data_q        <= data_d;
            err_q         <= err_d;
            ovf_q         <= ovf_d;
            evaltrigger_q <= evaltrigger_d;
            lvatrigger_q  <= lvatrigger_d;
            movedone_q    <= movedone_d;
            moveerr_q     <= moveerr_d;
        end
    end

    assign lvamovedone = movedone_q;
    assign moveerr     = moveerr_q;
    assign ovf         = ovf_q;
    assign full        = fifo_full;
    assign evalpush    = 1'b0;
    assign evaltrigger = evaltrigger_q;
    assign lvaop       = lvatrigger_q;
    assign lvatrigger  = lvatrigger_q;
    assign lvaindex    = idx_q;
    assign lvawrite    = data_q;

endmodule
